branch_resolve: RTL

ID-stage branch/jump resolution unit of the RV32I core. Consumes the forwarding selects `fa`/`fb` from `forwarding_br`, selects branch operands, and inserts stall cycles when a source is still in flight in EX (ALU or load) or MEM (load). It compares operands, computes the target and drives a registered PC redirect plus an IF/ID flush pulse.

---
 rtl/branch_resolve_pkg.sv | 42 ++++
 rtl/branch_resolve_br_cmp.sv | 26 ++
 rtl/branch_resolve.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the ID-stage branch resolution unit: funct3 conditions,
// forward-select codes, FSM states and the per-source hazard depth rule.
package branch_resolve_pkg;

    localparam logic [2:0] Funct3Beq  = 3'b000;
    localparam logic [2:0] Funct3Bne  = 3'b001;
    localparam logic [2:0] Funct3Blt  = 3'b100;
    localparam logic [2:0] Funct3Bge  = 3'b101;
    localparam logic [2:0] Funct3Bltu = 3'b110;
    localparam logic [2:0] Funct3Bgeu = 3'b111;

    localparam logic [1:0] FwdRegfile = 2'd0;
    localparam logic [1:0] FwdMem     = 2'd1;
    localparam logic [1:0] FwdWb      = 2'd2;

    localparam logic StIdle  = 1'b0;
    localparam logic StStall = 1'b1;

    // Cycles a source must wait before the forwarding network can supply it.
    function automatic logic [1:0] hazard_depth(
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_wb,
        input logic       ex_load,
        input logic [4:0] mem_rd,
        input logic       mem_load
    );
        logic [1:0] depth;
        depth = 2'd0;
        if (rs != 5'd0) begin
            if (ex_load && (ex_rd == rs)) begin
                depth = 2'd2;
            end else if (ex_wb && (ex_rd == rs)) begin
                depth = 2'd1;
            end else if (mem_load && (mem_rd == rs)) begin
                depth = 2'd1;
            end
        end
        return depth;
    endfunction

endpackage

// File: rtl/branch_resolve_br_cmp.sv
// Combinational branch condition evaluator (funct3 -> taken).
module br_cmp
    import branch_resolve_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      funct3,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            Funct3Beq:  taken = (op1 == op2);
            Funct3Bne:  taken = (op1 != op2);
            Funct3Blt:  taken = ($signed(op1) <  $signed(op2));
            Funct3Bge:  taken = ($signed(op1) >= $signed(op2));
            Funct3Bltu: taken = (op1 <  op2);
            Funct3Bgeu: taken = (op1 >= op2);
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch/jump resolution with load/ALU hazard stalls and registered redirect.
// Optional BR_PERF_EN adds conditional-branch resolved/taken counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_branch,
    input  logic            id_jal,
    input  logic            id_jalr,
    input  logic [2:0]      id_funct3,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      rs1id,
    input  logic [4:0]      rs2id,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [1:0]      fa,
    input  logic [1:0]      fb,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      mem_rd,
    input  logic            ex_wb,
    input  logic            ex_load,
    input  logic            mem_load,
    input  logic            kill,
    output logic            stall_id,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_ifid
`ifdef BR_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_taken
`endif
);

    logic            state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] op1, op2, jalr_sum, target;
    logic            cond_taken, taken, active, resolve;
    logic [1:0]      depth1, depth2, depth;

    always_comb begin
        case (fa)
            FwdMem:     op1 = mem_result;
            FwdWb:      op1 = wb_data;
            FwdRegfile: op1 = rs1_data;
            default:    op1 = rs1_data;
        endcase
        case (fb)
            FwdMem:     op2 = mem_result;
            FwdWb:      op2 = wb_data;
            FwdRegfile: op2 = rs2_data;
            default:    op2 = rs2_data;
        endcase
    end

    br_cmp #(
        .XLEN (XLEN)
    ) u_br_cmp (
        .op1    (op1),
        .op2    (op2),
        .funct3 (id_funct3),
        .taken  (cond_taken)
    );

    assign taken    = id_jal | id_jalr | (id_branch & cond_taken);
    assign jalr_sum = op1 + id_imm;
    assign target   = id_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (id_pc + id_imm);

    // The slot behind a redirect pulse holds a wrong-path instruction: ignore it.
    assign active = id_valid & (id_branch | id_jal | id_jalr) & ~redirect_valid;

    assign depth1 = (id_branch | id_jalr) ?
                    hazard_depth(rs1id, ex_rd, ex_wb, ex_load, mem_rd, mem_load) : 2'd0;
    assign depth2 = id_branch ?
                    hazard_depth(rs2id, ex_rd, ex_wb, ex_load, mem_rd, mem_load) : 2'd0;
    assign depth  = (depth1 > depth2) ? depth1 : depth2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_id = 1'b0;
        resolve  = 1'b0;
        if (kill) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
        end else if (state_q == StStall) begin
            stall_id = 1'b1;
            if (!id_valid || (cnt_q == 2'd1)) begin
                state_d = StIdle;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (active) begin
            if (depth != 2'd0) begin
                // This cycle is the first stall; only the remainder is counted in STALL.
                // A depth-1 hazard has cleared by the next cycle, so IDLE re-evaluates.
                stall_id = 1'b1;
                if (depth > 2'd1) begin
                    state_d = StStall;
                    cnt_d   = depth - 2'd1;
                end
            end else begin
                resolve = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= 2'd0;
            redirect_valid <= 1'b0;
            flush_ifid     <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            redirect_valid <= resolve & taken;
            flush_ifid     <= resolve & taken;
            if (resolve && taken) begin
                redirect_pc <= target;
            end
        end
    end

`ifdef BR_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches <= 32'd0;
            perf_taken    <= 32'd0;
        end else if (resolve && id_branch) begin
            perf_branches <= perf_branches + 32'd1;
            if (cond_taken) begin
                perf_taken <= perf_taken + 32'd1;
            end
        end
    end
`endif

endmodule
